// File: rtl/demux_sched_4ch_if.sv
// Handshake/data bundle between the upstream producer, the burst scheduler and the demux fabric.
// master = producer/fabric side, slave = scheduler side.
interface demux_sched_4ch_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        ch_en;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        out_ready;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        sel;
  logic              burst_done;

  modport master (
    output ch_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, burst_done
  );

  modport slave (
    input  ch_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, burst_done
  );
endinterface

// File: rtl/demux_sched_4ch.sv
// Round-robin burst scheduler driving the select of a 1-to-4 demux (BURST_LEN beats per grant).
// Optional stall timeout is compiled in with `define DEMUX_SCHED_TIMEOUT_EN.
module demux_sched_4ch #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  demux_sched_4ch_if.slave    bus,
  output logic [1:0]          state_dbg,
  output logic [3:0]          beat_cnt_dbg
);

  if (BURST_LEN < 1 || BURST_LEN > 15 || TIMEOUT < 1) begin : g_param_check
    $error("demux_sched_4ch: BURST_LEN must be 1..15 and TIMEOUT >= 1");
  end

  // Handshake: a beat moves on a cycle where state==XFER, in_valid=1 and
  // out_ready[sel]=1; in_ready/out_valid never wait on each other.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t     state;
  logic [1:0] sel_q;
  logic [1:0] last;
  logic [3:0] beat_cnt;
  logic       done_q;
  logic [1:0] next_ch;
  logic       fire;

`ifdef DEMUX_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  logic [STALL_W-1:0] stall_cnt;
`endif

  // First enabled channel after last, modulo 4; k=4 lands back on last itself.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    next_ch = last;
    found   = 1'b0;
    cand    = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + k[1:0];
      if (!found && bus.ch_en[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  assign fire         = (state == XFER) && bus.in_valid && bus.out_ready[sel_q];
  assign bus.in_ready = (state == XFER) && bus.out_ready[sel_q];
  assign bus.out_data = bus.in_data;
  assign bus.sel      = sel_q;
  assign bus.burst_done = done_q;
  assign state_dbg    = state;
  assign beat_cnt_dbg = beat_cnt;

  always_comb begin
    bus.out_valid = 4'b0000;
    if (state == XFER && bus.in_valid) bus.out_valid[sel_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 2'd0;
      last     <= 2'd3;
      beat_cnt <= 4'd0;
      done_q   <= 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      stall_cnt <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ch_en != 4'b0000) state <= PICK;
        end
        PICK: begin
          if (bus.ch_en == 4'b0000) begin
            state <= IDLE;
          end else begin
            sel_q    <= next_ch;
            last     <= next_ch;
            beat_cnt <= 4'd0;
            state    <= XFER;
`ifdef DEMUX_SCHED_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end
        end
        XFER: begin
          if (fire) begin
`ifdef DEMUX_SCHED_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (beat_cnt == LAST_BEAT) begin
              done_q   <= 1'b1;
              beat_cnt <= 4'd0;
              state    <= (bus.ch_en == 4'b0000) ? IDLE : PICK;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
              if (!bus.ch_en[sel_q]) state <= PICK;
            end
          end else begin
            // A granted channel that loses its enable gives up the grant with no done pulse.
            if (!bus.ch_en[sel_q]) begin
              state <= PICK;
            end
`ifdef DEMUX_SCHED_TIMEOUT_EN
            else if (stall_cnt == STALL_LAST) begin
              state     <= PICK;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_sched_4ch.sv
// Self-checking bench for demux_sched_4ch: vector tables, directed corner sequences
// and randomized traffic against a grant-level reference model.
module tb_demux_sched_4ch;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_sched_4ch_if #(.DATA_W(DATA_W)) bus ();
  logic [1:0] state_dbg;
  logic [3:0] beat_cnt_dbg;

  demux_sched_4ch #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .state_dbg(state_dbg), .beat_cnt_dbg(beat_cnt_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       first;
    logic [3:0] ch_en;
    logic       in_valid;
    logic [3:0] out_ready;
    logic [1:0] exp_sel;
    logic [3:0] exp_ov;
    logic       exp_ir;
    logic       exp_bd;
  } vec_t;
  vec_t vecs[$];

  logic [DATA_W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] en, input logic v, input logic [3:0] rdy);
    bus.ch_en     = en;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    bus.in_data   = DATA_W'($urandom_range(0, 255));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(4'b0000, 1'b0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] s, input logic [3:0] ov,
                            input logic ir, input logic bd);
    check({tag, "_sel"}, 32'(bus.sel), 32'(s));
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(ir));
    check({tag, "_burst_done"}, 32'(bus.burst_done), 32'(bd));
  endtask

  // One round-robin run from reset: IDLE, then PICK + BURST_LEN beats per grant.
  task automatic add_rr(input logic [3:0] en, input logic [1:0] g0, input logic [1:0] g1,
                        input logic [1:0] g2, input logic [1:0] g3, input logic [1:0] g4);
    logic [1:0] g[5];
    vec_t v;
    g = '{g0, g1, g2, g3, g4};
    v = '{first: 1'b1, ch_en: en, in_valid: 1'b1, out_ready: 4'b1111,
          exp_sel: 2'd0, exp_ov: 4'b0000, exp_ir: 1'b0, exp_bd: 1'b0};
    vecs.push_back(v);
    for (int b = 0; b <= 5; b++) begin
      v.first   = 1'b0;
      v.exp_sel = (b == 0) ? 2'd0 : g[b-1];
      v.exp_ov  = 4'b0000;
      v.exp_ir  = 1'b0;
      v.exp_bd  = (b > 0);
      vecs.push_back(v);
      if (b < 5) begin
        for (int k = 0; k < BURST_LEN; k++) begin
          v.exp_sel = g[b];
          v.exp_ov  = 4'b0001 << g[b];
          v.exp_ir  = 1'b1;
          v.exp_bd  = 1'b0;
          vecs.push_back(v);
        end
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Grant-level view: "none" (0), "choosing" (1) or "burst owner m_ch" (2).
  int m_phase, m_ch, m_last, m_beats, m_stall;
  logic m_done;

  task automatic model_reset();
    m_phase = 0; m_ch = 0; m_last = 3; m_beats = 0; m_stall = 0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] en, input logic v, input logic [3:0] rdy);
    bit moved;
    moved  = (m_phase == 2) && v && rdy[m_ch];
    m_done = 1'b0;
    if (m_phase == 0) begin
      if (en != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (en == 0) m_phase = 0;
      else begin
        for (int k = 1; k <= 4; k++) begin
          if (en[(m_last + k) % 4]) begin
            m_ch = (m_last + k) % 4;
            break;
          end
        end
        m_last = m_ch; m_beats = 0; m_stall = 0; m_phase = 2;
      end
    end else if (moved) begin
      m_beats++;
      m_stall = 0;
      if (m_beats == BURST_LEN) begin
        m_done = 1'b1; m_beats = 0;
        m_phase = (en == 0) ? 0 : 1;
      end else if (!en[m_ch]) m_phase = 1;
    end else if (!en[m_ch]) begin
      m_phase = 1;
    end else begin
`ifdef DEMUX_SCHED_TIMEOUT_EN
      m_stall++;
      if (m_stall == TIMEOUT) begin
        m_phase = 1; m_stall = 0;
      end
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int beats;
    bit seen_bd;
    logic [3:0] en;
    logic [3:0] exp_ov;

    // Reset values
    reset_dut();
    rst = 1'b1;
    #1;
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_beat_cnt", 32'(beat_cnt_dbg), 32'd0);
    check_outs("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table: round robin over all channels, then skipping disabled ones
    add_rr(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0);
    add_rr(4'b0101, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].first) reset_dut();
      else @(negedge clk);
      drive(vecs[i].ch_en, vecs[i].in_valid, vecs[i].out_ready);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_ov,
                 vecs[i].exp_ir, vecs[i].exp_bd);
      check($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(bus.in_data));
    end

    // Reset in the middle of a channel-1 burst, after 2 of 4 beats
    reset_dut();
    drive(4'b1111, 1'b1, 4'b1111);
    repeat (9) @(negedge clk);
    #1;
    check("midrst_pre_sel", 32'(bus.sel), 32'd1);
    check("midrst_pre_beats", 32'(beat_cnt_dbg), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_outs("midrst_async", 2'd0, 4'b0000, 1'b0, 1'b0);
    check("midrst_beat_cnt", 32'(beat_cnt_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outs("midrst_regrant", 2'd0, 4'b0001, 1'b1, 1'b0);
    check("midrst_regrant_beats", 32'(beat_cnt_dbg), 32'd0);

    // Backpressure on channel 1 for 6 cycles at the start of its burst
    reset_dut();
    drive(4'b1111, 1'b1, 4'b1111);
    repeat (7) @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      drive(4'b1111, 1'b1, 4'b1101);
      #1;
      check($sformatf("bp_stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp_stall%0d_beats", c), 32'(beat_cnt_dbg), 32'd0);
      check($sformatf("bp_stall%0d_sel", c), 32'(bus.sel), 32'd1);
      @(negedge clk);
    end
    beats = 0;
    seen_bd = 1'b0;
    for (int c = 0; c < 12 && !seen_bd; c++) begin
      drive(4'b1111, 1'b1, 4'b1111);
      #1;
      if (bus.burst_done) seen_bd = 1'b1;
      else begin
        if (bus.in_ready && bus.out_valid[1]) beats++;
        @(negedge clk);
      end
    end
    check("bp_burst_done_seen", 32'(seen_bd), 32'd1);
    check("bp_beats_after_ready", 32'(beats), 32'(BURST_LEN));

    // Drop ch_en[2] after beat 1 of a channel-2 burst
    reset_dut();
    drive(4'b1111, 1'b1, 4'b1111);
    repeat (12) @(negedge clk);
    #1;
    check_outs("dis_beat1", 2'd2, 4'b0100, 1'b1, 1'b0);
    @(negedge clk);
    drive(4'b1011, 1'b1, 4'b1111);
    #1;
    check_outs("dis_last_beat", 2'd2, 4'b0100, 1'b1, 1'b0);
    @(negedge clk);
    drive(4'b1011, 1'b1, 4'b1111);
    #1;
    check("dis_pick_state", 32'(state_dbg), 32'd1);
    check_outs("dis_pick", 2'd2, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    drive(4'b1011, 1'b1, 4'b1111);
    #1;
    check_outs("dis_grant3", 2'd3, 4'b1000, 1'b1, 1'b0);

    // Channel 0 never ready
    reset_dut();
    drive(4'b1111, 1'b1, 4'b1110);
    repeat (17) @(negedge clk);
    #1;
    check_outs("to_stall16", 2'd0, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    #1;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    check("to_pick_state", 32'(state_dbg), 32'd1);
    check_outs("to_pick", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_outs("to_grant1", 2'd1, 4'b0010, 1'b1, 1'b0);
`else
    check_outs("noto_hold", 2'd0, 4'b0001, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    #1;
    check_outs("noto_hold_long", 2'd0, 4'b0001, 1'b0, 1'b0);
    check("noto_state", 32'(state_dbg), 32'd2);
`endif

    // Randomized traffic against the reference model
    reset_dut();
    model_reset();
    en = 4'b1111;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 9 == 0) begin
        case ($urandom_range(0, 9))
          0:       en = 4'b0000;
          1, 2, 3: en = 4'b1111;
          default: en = 4'($urandom_range(1, 15));
        endcase
      end
      drive(en, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15) | $urandom_range(0, 15)));
      #1;
      exp_ov = (m_phase == 2 && bus.in_valid) ? (4'b0001 << m_ch) : 4'b0000;
      check_outs($sformatf("rnd%0d", c), 2'(m_ch), exp_ov,
                 (m_phase == 2) && bus.out_ready[m_ch], m_done);
      check($sformatf("rnd%0d_beat_max", c), 32'(beat_cnt_dbg < BURST_LEN), 32'd1);
      if (m_phase == 2 && bus.in_valid && bus.out_ready[m_ch])
        exp_q.push_back({2'(m_ch), bus.in_data});
      if ((bus.out_valid & bus.out_ready) != 4'b0000) begin
        logic [1:0] ch;
        ch = 2'd0;
        for (int k = 0; k < 4; k++) if (bus.out_valid[k]) ch = 2'(k);
        if (exp_q.size() == 0) check($sformatf("rnd%0d_sb_unexpected", c), 32'd1, 32'd0);
        else check($sformatf("rnd%0d_sb_beat", c), 32'({ch, bus.out_data}), 32'(exp_q.pop_front()));
      end
      model_step(bus.ch_en, bus.in_valid, bus.out_ready);
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
